// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and types for the round-robin / fixed-priority stream multiplexer.
package stream_mux_rr_pkg;

  localparam int unsigned MODE_RR   = 0;
  localparam int unsigned MODE_PRIO = 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/stream_mux_rr_if.sv
// NCH input streams plus one output stream; master is the mux side, slave is the sources/sink side.
interface stream_mux_rr_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned CH_W = $clog2(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [CH_W-1:0]      out_ch;
  logic                 out_ready;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating priority arbiter: rotate requests by ptr, pick the lowest set bit, rotate the index back.
module rr_arbiter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  input  logic            en_rr,
  output logic [NCH-1:0]  grant_c,
  output logic [CH_W-1:0] idx_c,
  output logic            any_c
);

  logic [CH_W-1:0] base;
  logic [CH_W-1:0] k;
  logic [NCH-1:0]  rot;
  logic            found;

  // Modular add without a divider so NCH need not be a power of two.
  function automatic logic [CH_W-1:0] add_mod(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    logic [CH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > (CH_W+1)'(NCH - 1)) s = s - (CH_W+1)'(NCH);
    return s[CH_W-1:0];
  endfunction

  always_comb begin
    base    = en_rr ? ptr : '0;
    rot     = '0;
    found   = 1'b0;
    k       = '0;
    grant_c = '0;
    for (int j = 0; j < NCH; j++) rot[j] = req[add_mod(base, CH_W'(j))];
    for (int j = 0; j < NCH; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        k     = CH_W'(j);
      end
    end
    any_c = found;
    idx_c = add_mod(k, base);
    if (found) grant_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with packet-locked round-robin or fixed-priority arbitration.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned MODE  = MODE_RR
) (
  input  logic            clk,
  input  logic            reset,
  stream_mux_rr_if.master bus
);
  localparam int unsigned CH_W = $clog2(NCH);

  lock_state_e     state_q, state_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;

  logic             load_c;
  logic             xfer_c;
  logic [NCH-1:0]   req_c;
  logic [NCH-1:0]   ready_c;
  logic [NCH-1:0]   arb_grant_c;
  logic [CH_W-1:0]  arb_idx_c;
  logic             arb_any_c;
  logic [WIDTH-1:0] sel_data_c;
  logic             sel_last_c;

  assign load_c = !out_valid_q || bus.out_ready;

  rr_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req     (req_c),
    .ptr     (rr_ptr_q),
    .en_rr   (MODE == MODE_RR),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c),
    .any_c   (arb_any_c)
  );

  // Lock FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Lock FSM: next state. A non-last beat locks onto its channel, a last beat releases.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (xfer_c) begin
      if (sel_last_c) begin
        state_d = UNLOCKED;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = arb_idx_c;
      end
    end
  end

  // Lock FSM: outputs. While locked only the owning channel may request.
  always_comb begin
    req_c   = bus.in_valid;
    ready_c = '0;
    if (state_q == LOCKED) req_c = bus.in_valid & (NCH'(1) << lock_ch_q);
    if (!reset && load_c && arb_any_c) ready_c = arb_grant_c;
  end

  assign bus.in_ready = ready_c;
  assign xfer_c       = |(bus.in_valid & ready_c);

  // AND-OR select of the granted beat.
  always_comb begin
    sel_data_c = '0;
    sel_last_c = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_grant_c[i]) begin
        sel_data_c = bus.in_data[i*WIDTH +: WIDTH];
        sel_last_c = bus.in_last[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if ((MODE == MODE_RR) && xfer_c && sel_last_c) begin
      rr_ptr_d = (arb_idx_c == CH_W'(NCH - 1)) ? '0 : arb_idx_c + CH_W'(1);
    end
    if (load_c) begin
      out_valid_d = xfer_c;
      if (xfer_c) begin
        out_data_d = sel_data_c;
        out_last_d = sel_last_c;
        out_ch_d   = arb_idx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

endmodule
